// File: rtl/spi_wb_arbiter.sv
// spi_wb_arbiter: shares the SPI master controller's Wishbone register port between
// master 0 (XIP read sequencer) and master 1 (CPU APB-to-Wishbone bridge).
// Grants round-robin per transfer. The owner may hold the bus across beats with mN_lock.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a beat the slave never answers.
module spi_wb_arbiter #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset,
  // master 0
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_wdat,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic                m0_lock,
  output logic [DATA_W-1:0]   m0_rdat,
  output logic                m0_ack,
  output logic                m0_err,
  // master 1
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_wdat,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic                m1_lock,
  output logic [DATA_W-1:0]   m1_rdat,
  output logic                m1_ack,
  output logic                m1_err,
  // slave (SPI controller register port)
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_wdat,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_rdat,
  input  logic                s_ack,
  input  logic                s_err,
  // status
  output logic [1:0]          gnt,
  output logic                timeout
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;  // 0: master 0 owned last, 1: master 1 owned last
  logic   req0, req1, own0, own1, beat_end, abort;

  assign req0     = m0_cyc & m0_stb;
  assign req1     = m1_cyc & m1_stb;
  assign own0     = (state_q == StOwn0);
  assign own1     = (state_q == StOwn1);
  assign beat_end = (own0 | own1) & (s_ack | s_err);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            stall;

  assign stall = (own0 | own1) & s_stb & ~s_ack & ~s_err;
  assign abort = stall & (wd_cnt_q == CntW'(TIMEOUT_CYC - 1));

  // Watchdog count of unanswered strobe cycles; restarts on every beat end or release.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_d == StIdle) || beat_end) begin
      wd_cnt_d = '0;
    end else if (stall) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign abort = 1'b0;
`endif

  // Ownership FSM: grant, lock hold, release on beat end, dropped cycle or abort.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_gnt_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (abort) begin
          state_d    = StIdle;
          last_gnt_d = 1'b0;
        end else if (beat_end) begin
          if (!(m0_lock && m0_cyc)) begin
            state_d    = StIdle;
            last_gnt_d = 1'b0;
          end
        end else if (!m0_cyc) begin
          state_d    = StIdle;
          last_gnt_d = 1'b0;
        end
      end
      StOwn1: begin
        if (abort) begin
          state_d    = StIdle;
          last_gnt_d = 1'b1;
        end else if (beat_end) begin
          if (!(m1_lock && m1_cyc)) begin
            state_d    = StIdle;
            last_gnt_d = 1'b1;
          end
        end else if (!m1_cyc) begin
          state_d    = StIdle;
          last_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and round-robin history; last_gnt resets to 1 so master 0 wins first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Datapath steering: owner drives the slave, slave responses go only to the owner.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_wdat  = '0;
    s_sel   = '0;
    m0_rdat = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_rdat = '0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    if (own0) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_wdat  = m0_wdat;
      s_sel   = m0_sel;
      m0_rdat = s_rdat;
      m0_ack  = s_ack;
      m0_err  = s_err | abort;
    end else if (own1) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_wdat  = m1_wdat;
      s_sel   = m1_sel;
      m1_rdat = s_rdat;
      m1_ack  = s_ack;
      m1_err  = s_err | abort;
    end
  end

  assign gnt     = {own1, own0};
  assign timeout = abort;

endmodule
